er_exec_sequencer: RTL and testbench



---
 rtl/vape_pkg.sv | 22 ++
 rtl/er_att_if.sv | 49 ++++
 rtl/er_exec_sequencer.sv | 133 +++++++++++++
 tb/tb_er_exec_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vape_pkg.sv
// ============================================================================
// Module   : vape_pkg
// Brief    : Shared types and defaults for the ER execution sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vape_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } er_state_t;

endpackage

`default_nettype wire

// File: rtl/er_att_if.sv
// ============================================================================
// Module   : er_att_if
// Brief    : 4-phase attestation handshake with exec/run-count snapshots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module er_att_if
    import vape_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             att_req,
    input  logic             exec_live,
    input  logic [CNT_W-1:0] cnt_live,
    output logic             att_ack,
    output logic             att_exec,
    output logic [CNT_W-1:0] att_cnt
);

    logic             r_ack;
    logic             r_exec;
    logic [CNT_W-1:0] r_cnt;

    // Snapshots are only loaded on acceptance, so they stay frozen for the
    // whole time the acknowledge is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack  <= 1'b0;
            r_exec <= 1'b0;
            r_cnt  <= '0;
        end else if (!r_ack && att_req) begin
            r_ack  <= 1'b1;
            r_exec <= exec_live;
            r_cnt  <= cnt_live;
        end else if (r_ack && !att_req) begin
            r_ack  <= 1'b0;
        end
    end

    assign att_ack  = r_ack;
    assign att_exec = r_exec;
    assign att_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: rtl/er_exec_sequencer.sv
// ============================================================================
// Module   : er_exec_sequencer
// Brief    : Registered proof-of-execution FSM for the executable region.
//            Build option VAPE_DMA_ABORT_EN: DMA inside ER aborts the run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module er_exec_sequencer
    import vape_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              irq,
    input  logic              dma_en,
    input  logic              viol,
    input  logic [ADDR_W-1:0] ER_min,
    input  logic [ADDR_W-1:0] ER_max,
    input  logic              cfg_wr,
    input  logic              att_req,
    output logic              att_ack,
    output logic              att_exec,
    output logic [CNT_W-1:0]  att_cnt,
    output logic              exec,
    output logic [1:0]        state_o
);

    er_state_t         r_state;
    logic              r_exec;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_pc_prev;

    logic w_in_er;
    logic w_fault;
    logic w_at_entry;
    logic w_legal_exit;
    logic w_cnt_full;

    assign w_in_er = (pc >= ER_min) && (pc <= ER_max);

`ifdef VAPE_DMA_ABORT_EN
    assign w_fault = (w_in_er && (irq || dma_en)) || viol;
`else
    logic w_unused_dma;
    assign w_unused_dma = dma_en;
    assign w_fault      = (w_in_er && irq) || viol;
`endif

    assign w_at_entry   = (pc == ER_min);
    assign w_legal_exit = !w_in_er && (r_pc_prev == ER_max);
    assign w_cnt_full   = (r_cnt == {CNT_W{1'b1}});

    // exec is loaded alongside the state so it is high exactly in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_exec    <= 1'b0;
            r_cnt     <= '0;
            r_pc_prev <= '0;
        end else begin
            r_pc_prev <= pc;
            if (cfg_wr) begin
                r_state <= ST_IDLE;
                r_exec  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_ABORT: begin
                        if (w_at_entry && !w_fault) begin
                            r_state <= ST_RUN;
                            r_exec  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (w_fault) begin
                            r_state <= ST_ABORT;
                            r_exec  <= 1'b0;
                        end else if (w_legal_exit) begin
                            r_state <= ST_DONE;
                            r_exec  <= 1'b1;
                            if (!w_cnt_full) begin
                                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else if (!w_in_er) begin
                            r_state <= ST_ABORT;
                            r_exec  <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        if (viol) begin
                            r_state <= ST_ABORT;
                            r_exec  <= 1'b0;
                        end else if (w_at_entry && !w_fault) begin
                            r_state <= ST_RUN;
                            r_exec  <= 1'b0;
                        end else if (w_in_er) begin
                            // Mid-region entry, or a fault landing on the entry point.
                            r_state <= ST_ABORT;
                            r_exec  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_exec  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign exec    = r_exec;
    assign state_o = r_state;

    er_att_if #(
        .CNT_W (CNT_W)
    ) u_att_if (
        .clk       (clk),
        .reset     (reset),
        .att_req   (att_req),
        .exec_live (r_exec),
        .cnt_live  (r_cnt),
        .att_ack   (att_ack),
        .att_exec  (att_exec),
        .att_cnt   (att_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_er_exec_sequencer.sv
// ============================================================================
// Module   : tb_er_exec_sequencer
// Brief    : Directed self-checking bench for er_exec_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_er_exec_sequencer;

    localparam int c_ADDR_W = 16;
    localparam int c_CNT_W  = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [c_ADDR_W-1:0] pc;
    logic                irq;
    logic                dma_en;
    logic                viol;
    logic [c_ADDR_W-1:0] ER_min;
    logic [c_ADDR_W-1:0] ER_max;
    logic                cfg_wr;
    logic                att_req;
    logic                att_ack;
    logic                att_exec;
    logic [c_CNT_W-1:0]  att_cnt;
    logic                exec;
    logic [1:0]          state_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    er_exec_sequencer #(
        .ADDR_W (c_ADDR_W),
        .CNT_W  (c_CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .irq      (irq),
        .dma_en   (dma_en),
        .viol     (viol),
        .ER_min   (ER_min),
        .ER_max   (ER_max),
        .cfg_wr   (cfg_wr),
        .att_req  (att_req),
        .att_ack  (att_ack),
        .att_exec (att_exec),
        .att_cnt  (att_cnt),
        .exec     (exec),
        .state_o  (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] addr);
        pc = addr;
        tick();
    endtask

    task automatic cfg_pulse();
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic run_to(input logic [15:0] last);
        for (int a = 'hE000; a <= int'(last); a += 2) begin
            go(a[15:0]);
        end
    endtask

    task automatic run_full(input string tag);
        run_to(16'hE0FE);
        go(16'hF000);
        chk({tag, "_state"}, state_o, 2);
        chk({tag, "_exec"}, exec, 1);
    endtask

    task automatic hs(input string tag, input logic exp_exec, input logic [7:0] exp_cnt);
        att_req = 1'b1;
        tick();
        chk({tag, "_ack"}, att_ack, 1);
        chk({tag, "_att_exec"}, att_exec, exp_exec);
        chk({tag, "_att_cnt"}, att_cnt, exp_cnt);
        att_req = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, att_ack, 0);
    endtask

    initial begin
        reset   = 1'b1;
        pc      = 16'h0000;
        irq     = 1'b0;
        dma_en  = 1'b0;
        viol    = 1'b0;
        ER_min  = 16'hE000;
        ER_max  = 16'hE0FE;
        cfg_wr  = 1'b0;
        att_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_state", state_o, 0);
        chk("rst_exec", exec, 0);
        chk("rst_ack", att_ack, 0);
        chk("rst_att_exec", att_exec, 0);
        chk("rst_att_cnt", att_cnt, 0);
        tick();
        chk("idle_hold", state_o, 0);

        // Clean run, then handshake with snapshot hold across re-entry
        run_full("clean1");
        att_req = 1'b1;
        tick();
        chk("hs1_ack", att_ack, 1);
        chk("hs1_att_exec", att_exec, 1);
        chk("hs1_att_cnt", att_cnt, 1);
        go(16'hE000);
        chk("reentry_state", state_o, 1);
        chk("reentry_exec", exec, 0);
        chk("hs1_ack_hold", att_ack, 1);
        chk("hs1_exec_hold", att_exec, 1);
        att_req = 1'b0;
        tick();
        chk("hs1_ack_drop", att_ack, 0);
        go(16'hE0FE);
        go(16'hF000);
        chk("clean2_state", state_o, 2);

        // Mid-region entry from DONE
        go(16'hE040);
        chk("midentry_state", state_o, 3);
        chk("midentry_exec", exec, 0);
        hs("hs2", 1'b0, 8'd2);

        cfg_pulse();
        chk("cfg_state", state_o, 0);
        chk("cfg_exec", exec, 0);

        // Interrupt inside ER aborts; later clean run counts from zero
        run_to(16'hE00E);
        irq = 1'b1;
        go(16'hE010);
        irq = 1'b0;
        chk("irq_state", state_o, 3);
        chk("irq_exec", exec, 0);
        go(16'hF000);
        run_full("after_irq");
        hs("hs3", 1'b1, 8'd1);

        // Illegal exit from the middle of ER
        cfg_pulse();
        run_to(16'hE050);
        go(16'hF000);
        chk("illexit_state", state_o, 3);
        chk("illexit_exec", exec, 0);
        hs("hs4", 1'b0, 8'd0);

        // cfg_wr coinciding with a legal exit
        run_full("pre_cfg");
        hs("hs5", 1'b1, 8'd1);
        run_to(16'hE0FE);
        cfg_wr = 1'b1;
        go(16'hF000);
        cfg_wr = 1'b0;
        chk("cfgexit_state", state_o, 0);
        chk("cfgexit_exec", exec, 0);
        hs("hs6", 1'b0, 8'd0);

        // DMA inside ER: aborts only with the build option enabled
        run_to(16'hE01E);
        dma_en = 1'b1;
        go(16'hE020);
        dma_en = 1'b0;
`ifdef VAPE_DMA_ABORT_EN
        chk("dma_state", state_o, 3);
`else
        chk("dma_state", state_o, 1);
`endif
        go(16'hF000);
        chk("dma_exit_state", state_o, 3);

        // viol on the legal-exit cycle aborts
        run_to(16'hE0FE);
        viol = 1'b1;
        go(16'hF000);
        viol = 1'b0;
        chk("viol_exit_state", state_o, 3);
        chk("viol_exit_exec", exec, 0);

        // Counter saturation over 256 short legal runs
        cfg_pulse();
        for (int r = 0; r < 256; r++) begin
            go(16'hE000);
            go(16'hE0FE);
            go(16'hF000);
        end
        chk("sat_state", state_o, 2);
        hs("hs_sat", 1'b1, 8'd255);

        // Asynchronous reset during a handshake
        att_req = 1'b1;
        tick();
        chk("arst_pre_ack", att_ack, 1);
        reset = 1'b1;
        #1;
        chk("arst_ack", att_ack, 0);
        chk("arst_state", state_o, 0);
        chk("arst_exec", exec, 0);
        chk("arst_att_cnt", att_cnt, 0);
        reset   = 1'b0;
        att_req = 1'b0;
        tick();
        hs("hs_post_rst", 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
